hanoi_ctrl: RTL

HANOI_CTRL -- requirements
Module: hanoi_ctrl

---
 rtl/hanoi_pkg.sv | 22 ++
 rtl/hanoi_if.sv | 28 ++
 rtl/hanoi_top_find.sv | 24 ++
 rtl/hanoi_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hanoi_pkg.sv
// Shared types and constants for the Tower-of-Hanoi move controller.
//   state_e    : controller FSM states
//   err_code_e : reason reported with err on an illegal move
//   NumRods    : number of rods
package hanoi_pkg;

  localparam int unsigned NumRods = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAuto = 2'd1,
    StFin  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ErrNone       = 2'd0,
    ErrBadRod     = 2'd1,
    ErrSrcEmpty   = 2'd2,
    ErrBigOnSmall = 2'd3
  } err_code_e;

endpackage

// File: rtl/hanoi_if.sv
// Move request / completion handshake of the Hanoi controller.
//   move_valid, move_fr, move_to : manual move request (master -> slave)
//   move_ready                   : manual move can be accepted this cycle
//   auto_start                   : request an automatic solve
//   done, err, err_code          : one-cycle completion pulse with error status
interface hanoi_if;
  import hanoi_pkg::*;

  logic      move_valid;
  logic [1:0] move_fr;
  logic [1:0] move_to;
  logic      move_ready;
  logic      auto_start;
  logic      done;
  logic      err;
  err_code_e err_code;

  modport master (
    output move_valid, move_fr, move_to, auto_start,
    input  move_ready, done, err, err_code
  );

  modport slave (
    input  move_valid, move_fr, move_to, auto_start,
    output move_ready, done, err, err_code
  );

endinterface

// File: rtl/hanoi_top_find.sv
// Lowest-set-bit encoder: locates the top (smallest) disk on one rod.
//   mask  : rod occupancy, bit 0 is the smallest disk
//   idx   : index of the lowest set bit (0 when empty)
//   empty : mask has no bit set
module hanoi_top_find #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         mask,
  output logic [$clog2(N)-1:0] idx,
  output logic                 empty
);

  localparam int unsigned IdxW = $clog2(N);

  always_comb begin
    idx = '0;
    // Scan downwards so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IdxW'(i);
    end
    empty = (mask == '0);
  end

endmodule

// File: rtl/hanoi_ctrl.sv
// Tower-of-Hanoi controller: validates and applies manual moves and can run
// the optimal iterative solve, one move per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   bus (hanoi_if.slave): move handshake, auto_start, done/err/err_code
//   rod0..rod2          : occupancy masks, bit 0 is the smallest disk
//   move_cnt            : legal moves performed (saturating)
//   busy                : automatic solve in progress
//   solved              : all disks on rod2
module hanoi_ctrl import hanoi_pkg::*; #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  hanoi_if.slave        bus,
  output logic [N-1:0]  rod0,
  output logic [N-1:0]  rod1,
  output logic [N-1:0]  rod2,
  output logic [CW-1:0] move_cnt,
  output logic          busy,
  output logic          solved
);

  localparam int unsigned IdxW = $clog2(N);
  // Step counter value when the final (2^N-1)-th move is being performed.
  localparam logic [N-1:0] LastStep = {{(N - 1){1'b1}}, 1'b0};

  state_e          state_q, state_d;
  logic [N-1:0]    rod_q [NumRods];
  logic [N-1:0]    rod_d [NumRods];
  logic [IdxW-1:0] top [NumRods];
  logic [NumRods-1:0] empty;
  logic [N-1:0]    step_q;
  logic [CW-1:0]   move_cnt_q;
  logic            done_q, err_q;
  err_code_e       err_code_q;

  logic            start, accept, do_move;
  logic [1:0]      d0_rod, oth_a, oth_b, auto_fr, auto_to, mv_fr, mv_to;
  logic [IdxW-1:0] src_top, dst_top;
  logic            src_empty, dst_empty;
  err_code_e       code;
  logic [N-1:0]    bit_mask;

  for (genvar r = 0; r < NumRods; r++) begin : g_find
    hanoi_top_find #(.N(N)) u_find (
      .mask  (rod_q[r]),
      .idx   (top[r]),
      .empty (empty[r])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.auto_start) state_d = StAuto;
      StAuto:  if (step_q == LastStep) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.move_ready = (state_q == StIdle) && !bus.auto_start;
    busy           = (state_q != StIdle);
  end

  assign start   = (state_q == StIdle) && bus.auto_start;
  assign accept  = bus.move_valid && bus.move_ready;
  assign do_move = accept || (state_q == StAuto);

  // Iterative solver: odd steps rotate disk 0, even steps make the only
  // legal move between the other two rods.
  always_comb begin
    d0_rod = 2'd0;
    for (int r = 0; r < NumRods; r++) begin
      if (rod_q[r][0]) d0_rod = 2'(r);
    end
    case (d0_rod)
      2'd0:    begin oth_a = 2'd1; oth_b = 2'd2; end
      2'd1:    begin oth_a = 2'd0; oth_b = 2'd2; end
      default: begin oth_a = 2'd0; oth_b = 2'd1; end
    endcase
    if (!step_q[0]) begin
      auto_fr = d0_rod;
      if (N % 2 == 0) auto_to = (d0_rod == 2'd2) ? 2'd0 : d0_rod + 2'd1;
      else            auto_to = (d0_rod == 2'd0) ? 2'd2 : d0_rod - 2'd1;
    end else if (empty[oth_a]) begin
      auto_fr = oth_b; auto_to = oth_a;
    end else if (empty[oth_b] || (top[oth_a] < top[oth_b])) begin
      auto_fr = oth_a; auto_to = oth_b;
    end else begin
      auto_fr = oth_b; auto_to = oth_a;
    end
  end

  // Move legality and resulting rod masks.
  always_comb begin
    mv_fr = (state_q == StAuto) ? auto_fr : bus.move_fr;
    mv_to = (state_q == StAuto) ? auto_to : bus.move_to;
    src_top = '0; src_empty = 1'b1;
    dst_top = '0; dst_empty = 1'b1;
    for (int r = 0; r < NumRods; r++) begin
      if (2'(r) == mv_fr) begin src_top = top[r]; src_empty = empty[r]; end
      if (2'(r) == mv_to) begin dst_top = top[r]; dst_empty = empty[r]; end
    end
    code = ErrNone;
    if ((mv_fr == mv_to) || (mv_fr == 2'd3) || (mv_to == 2'd3)) code = ErrBadRod;
    else if (src_empty)                                         code = ErrSrcEmpty;
    else if (!dst_empty && (dst_top < src_top))                 code = ErrBigOnSmall;
    bit_mask = {{(N - 1){1'b0}}, 1'b1} << src_top;
    for (int r = 0; r < NumRods; r++) begin
      rod_d[r] = rod_q[r];
      if (2'(r) == mv_fr) rod_d[r] = rod_d[r] & ~bit_mask;
      if (2'(r) == mv_to) rod_d[r] = rod_d[r] | bit_mask;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rod_q[0]   <= '1;
      rod_q[1]   <= '0;
      rod_q[2]   <= '0;
      move_cnt_q <= '0;
      step_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
      if (start) begin
        rod_q[0]   <= '1;
        rod_q[1]   <= '0;
        rod_q[2]   <= '0;
        move_cnt_q <= '0;
        step_q     <= '0;
      end else if (do_move) begin
        done_q     <= 1'b1;
        err_q      <= (code != ErrNone);
        err_code_q <= code;
        if (code == ErrNone) begin
          for (int r = 0; r < NumRods; r++) rod_q[r] <= rod_d[r];
          if (move_cnt_q != '1) move_cnt_q <= move_cnt_q + 1'b1;
        end
        if (state_q == StAuto) step_q <= step_q + 1'b1;
      end
    end
  end

  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;
  assign rod0         = rod_q[0];
  assign rod1         = rod_q[1];
  assign rod2         = rod_q[2];
  assign move_cnt     = move_cnt_q;
  assign solved       = (rod_q[2] == '1) && (rod_q[0] == '0) && (rod_q[1] == '0);

endmodule
